// File: rtl/sram_ctrl_pkg.sv
// Shared types for the sram initiator: FSM state encoding.
package sram_ctrl_pkg;
  typedef enum logic [1:0] {INIT, IDLE, RD, RESP} sram_ctrl_state_t;
endpackage

// File: rtl/sram_ctrl.sv
// Valid/ready front end for one synchronous sram: posted writes, blocking reads,
// and a full-array clear sweep after reset or on init_start.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int                    SIZE          = 16,
  parameter int                    DATA_WIDTH    = 4,
  parameter bit                    INIT_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
  localparam int                   AW            = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_start,
  output logic                  init_busy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [AW-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  sram_en,
  output logic                  sram_rw,
  output logic [AW-1:0]         sram_addr,
  output logic [DATA_WIDTH-1:0] sram_in,
  input  logic [DATA_WIDTH-1:0] sram_out
);

  sram_ctrl_state_t state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             rd_err_q;
  logic             in_range;

  // Non-power-of-two arrays leave a hole at the top of the address space.
  assign in_range = ({1'b0, req_addr} < (AW+1)'(SIZE));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_busy = 1'b0;
    req_ready = 1'b0;
    sram_en   = 1'b0;
    sram_rw   = 1'b0;
    sram_addr = '0;
    sram_in   = '0;
    case (state_q)
      INIT: begin
        init_busy = 1'b1;
        sram_en   = 1'b1;
        sram_rw   = 1'b1;
        sram_addr = cnt_q;
        sram_in   = INIT_VALUE;
        if (cnt_q == AW'(SIZE - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        req_ready = !init_start;
        sram_en   = req_valid & req_ready & in_range;
        sram_rw   = req_rw;
        sram_addr = req_addr;
        sram_in   = req_wdata;
        if (init_start)              state_d = INIT;
        else if (req_valid && !req_rw) state_d = RD;
      end
      RD:      state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Keep the sram port quiet while reset is held, even though state sits in INIT.
    if (!rst) begin
      init_busy = 1'b0;
      req_ready = 1'b0;
      sram_en   = 1'b0;
      sram_rw   = 1'b0;
      sram_addr = '0;
      sram_in   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= INIT_ON_RESET ? INIT : IDLE;
      cnt_q     <= '0;
      rd_err_q  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && state_d == RD) rd_err_q <= !in_range;
      if (state_q == RD) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= rd_err_q ? '0 : sram_out;
        rsp_err   <= rd_err_q;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench: two controllers (16-word and 12-word) each driving a behavioural sram.
module tb_sram_ctrl;
  typedef struct packed {logic err; logic [3:0] data;} exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  exp_t exp_q[$];

  // 16-word instance
  logic       a_rst, a_init_start, a_init_busy, a_req_valid, a_req_ready, a_req_rw;
  logic [3:0] a_req_addr, a_req_wdata, a_rsp_rdata, a_sram_addr, a_sram_in, a_sram_out;
  logic       a_rsp_valid, a_rsp_ready, a_rsp_err, a_sram_en, a_sram_rw;
  // 12-word instance
  logic       b_rst, b_init_start, b_init_busy, b_req_valid, b_req_ready, b_req_rw;
  logic [3:0] b_req_addr, b_req_wdata, b_rsp_rdata, b_sram_addr, b_sram_in, b_sram_out;
  logic       b_rsp_valid, b_rsp_ready, b_rsp_err, b_sram_en, b_sram_rw;

  sram_ctrl #(.SIZE(16), .DATA_WIDTH(4), .INIT_ON_RESET(1'b1), .INIT_VALUE(4'h0)) dut_a (
    .clk(clk), .rst(a_rst), .init_start(a_init_start), .init_busy(a_init_busy),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_rw(a_req_rw),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid),
    .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .sram_en(a_sram_en), .sram_rw(a_sram_rw), .sram_addr(a_sram_addr),
    .sram_in(a_sram_in), .sram_out(a_sram_out));

  sram_ctrl #(.SIZE(12), .DATA_WIDTH(4), .INIT_ON_RESET(1'b1), .INIT_VALUE(4'h0)) dut_b (
    .clk(clk), .rst(b_rst), .init_start(b_init_start), .init_busy(b_init_busy),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_rw(b_req_rw),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .sram_en(b_sram_en), .sram_rw(b_sram_rw), .sram_addr(b_sram_addr),
    .sram_in(b_sram_in), .sram_out(b_sram_out));

  // Behavioural srams, preloaded with F so the clear sweep is observable.
  logic [3:0] mem_a [16] = '{default: 4'hF};
  logic [3:0] mem_b [16] = '{default: 4'hF};
  always @(posedge clk) begin
    if (a_sram_en && a_sram_rw)  mem_a[a_sram_addr] <= a_sram_in;
    if (a_sram_en && !a_sram_rw) a_sram_out <= mem_a[a_sram_addr];
    if (b_sram_en && b_sram_rw)  mem_b[b_sram_addr] <= b_sram_in;
    if (b_sram_en && !b_sram_rw) b_sram_out <= mem_b[b_sram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [3:0] addr, input logic [3:0] data);
    a_req_valid = 1'b1; a_req_rw = 1'b1; a_req_addr = addr; a_req_wdata = data;
    #1;
    chk("wr_ready", a_req_ready, 1'b1);
    chk("wr_port", {a_sram_en, a_sram_rw, a_sram_addr, a_sram_in}, {1'b1, 1'b1, addr, data});
    @(negedge clk);
    a_req_valid = 1'b0;
  endtask

  // Read with an optional number of cycles of response back-pressure.
  task automatic rd_a(input logic [3:0] addr, input logic [3:0] data, input int hold);
    int   k;
    exp_t e;
    a_req_valid = 1'b1; a_req_rw = 1'b0; a_req_addr = addr;
    a_rsp_ready = (hold == 0);
    #1;
    chk("rd_ready", a_req_ready, 1'b1);
    exp_q.push_back({1'b0, data});
    @(negedge clk);
    a_req_valid = 1'b0;
    k = 1;
    while (!a_rsp_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("rd_latency", k, 2);
    e = exp_q.pop_front();
    chk("rd_data", {a_rsp_err, a_rsp_rdata}, e);
    for (int i = 0; i < hold; i++) begin
      chk("hold_stable", {a_rsp_valid, a_req_ready, a_rsp_err, a_rsp_rdata}, {1'b1, 1'b0, e});
      @(negedge clk);
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_done", {a_rsp_valid, a_req_ready}, 2'b01);
  endtask

  initial begin
    int   k;
    exp_t e;
    a_rst = 1'b0; a_init_start = 1'b0; a_req_valid = 1'b0; a_req_rw = 1'b0;
    a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b1;
    b_rst = 1'b0; b_init_start = 1'b0; b_req_valid = 1'b0; b_req_rw = 1'b0;
    b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {a_init_busy, a_req_ready, a_rsp_valid, a_rsp_err, a_sram_en, a_rsp_rdata},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});

    // 1: sweep after reset release
    a_rst = 1'b1; b_rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("sweep", {a_init_busy, a_req_ready, a_sram_en, a_sram_rw, a_sram_addr, a_sram_in},
          {1'b1, 1'b0, 1'b1, 1'b1, i[3:0], 4'h0});
      @(negedge clk);
    end
    chk("sweep_end", {a_init_busy, a_req_ready}, 2'b01);

    // 2: write then read back one word
    wr_a(4'd3, 4'hA);
    rd_a(4'd3, 4'hA, 0);

    // 3: back-to-back writes of the whole array, then readback
    for (int i = 0; i < 16; i++) wr_a(i[3:0], i[3:0]);
    for (int i = 0; i < 16; i++) rd_a(i[3:0], i[3:0], 0);

    // 4: response back-pressure
    rd_a(4'd9, 4'h9, 5);

    // 5: init_start beats a same-cycle write
    a_init_start = 1'b1; a_req_valid = 1'b1; a_req_rw = 1'b1; a_req_addr = 4'd5; a_req_wdata = 4'h7;
    #1;
    chk("init_prio", {a_req_ready, a_sram_en}, 2'b00);
    @(negedge clk);
    a_init_start = 1'b0; a_req_valid = 1'b0;
    k = 0;
    while (a_init_busy && k < 40) begin
      k++;
      @(negedge clk);
    end
    chk("reinit_len", k, 16);
    rd_a(4'd5, 4'h0, 0);
    rd_a(4'd12, 4'h0, 0);

    // 6: out-of-range read on the 12-word controller, then reset during RESP
    b_req_valid = 1'b1; b_req_rw = 1'b0; b_req_addr = 4'd13;
    #1;
    chk("b_oor_accept", {b_req_ready, b_sram_en}, 2'b10);
    exp_q.push_back({1'b1, 4'h0});
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("b_rd_quiet", {b_sram_en, b_rsp_valid}, 2'b00);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("b_err_rsp", {b_rsp_valid, b_sram_en, b_rsp_err, b_rsp_rdata}, {1'b1, 1'b0, e});
    #2 b_rst = 1'b0;
    #1;
    chk("b_rst_drop", {b_rsp_valid, b_sram_en, b_init_busy, b_req_ready}, 4'b0000);
    @(negedge clk);
    b_rst = 1'b1;
    #1;
    k = 0;
    while (b_init_busy && k < 40) begin
      k++;
      @(negedge clk);
    end
    chk("b_reinit_len", k, 12);
    chk("b_idle", {b_req_ready, b_rsp_valid}, 2'b10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
